// File: rtl/dense_layer_engine.sv
// dense_layer_engine: fully-connected layer, out[o] = act(bias[o] + sum_i w[o][i]*x[i]), LANES MACs per cycle
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    pass launch pulse (ignored while busy), synchronous abort to IDLE
//   relu_en         ReLU (1) / linear (0), latched on an accepted start
//   busy, done      pass in flight, one-cycle completion pulse
//   in_rd_*         activation segment s (lane k at bits [k*DATA_W +: DATA_W])
//   w_rd_*          weight segment o*SEG+s, same lane packing
//   b_rd_*          bias of neuron o
//   out_wr_*        activated, saturated result of neuron o
module dense_layer_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int LANES   = 25,
  parameter int IN_LEN  = 120,
  parameter int OUT_LEN = 84,
  parameter int ACC_W   = 40,
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       in_rd_addr,
  input  logic [LANES*DATA_W-1:0] in_rd_data,
  output logic [ADDR_W-1:0]       w_rd_addr,
  input  logic [LANES*DATA_W-1:0] w_rd_data,
  output logic [ADDR_W-1:0]       b_rd_addr,
  input  logic [DATA_W-1:0]       b_rd_data,
  output logic                    out_wr_en,
  output logic [ADDR_W-1:0]       out_wr_addr,
  output logic [DATA_W-1:0]       out_wr_data
);
  localparam int SEG = (IN_LEN + LANES - 1) / LANES;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] o_q, o_d, s_q, s_d, w_q, w_d;
  logic relu_q;
  logic iss, seg_end, last_iss, empty;
  logic [MEM_LAT-1:0] v_q, f_q, l_q;
  logic [ADDR_W-1:0] to_q [MEM_LAT];
  logic [ADDR_W-1:0] ts_q [MEM_LAT];
  logic [2*DATA_W-1:0] prod_q [LANES];
  logic [2*DATA_W-1:0] prod_d [LANES];
  logic [DATA_W-1:0] bp_q;
  logic vp_q, fp_q, lp_q;
  logic [ADDR_W-1:0] op_q;
  logic va_q, la_q;
  logic [ADDR_W-1:0] oa_q;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [ACC_W-DATA_W:0] hi;
  logic ovf;
  logic [DATA_W-1:0] sat_v, act_v;
  logic we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  assign iss      = state_q == RUN;
  assign seg_end  = s_q == ADDR_W'(SEG - 1);
  assign last_iss = iss && seg_end && o_q == ADDR_W'(OUT_LEN - 1);
  // Final write leaves the accumulate stage exactly when these all drain
  assign empty    = ~|{v_q, vp_q, va_q};
  assign busy        = state_q != IDLE;
  assign done        = state_q == FIN;
  assign in_rd_addr  = s_q;
  // o*SEG+s is just the running issue count, so no multiplier is needed
  assign w_rd_addr   = w_q;
  assign b_rd_addr   = o_q;
  assign out_wr_en   = we_q;
  assign out_wr_addr = wa_q;
  assign out_wr_data = wd_q;
  always_comb begin
    state_d = abort                          ? IDLE  :
              (state_q == IDLE && start)     ? RUN   :
              last_iss                       ? DRAIN :
              (state_q == DRAIN && empty)    ? FIN   :
              (state_q == FIN)               ? IDLE  : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    o_d = o_q;
    s_d = s_q;
    w_d = w_q;
    if (abort) begin
      o_d = '0;
      s_d = '0;
      w_d = '0;
    end else if (iss) begin
      s_d = seg_end ? '0 : s_q + ADDR_W'(1);
      o_d = last_iss ? '0 : o_q + ADDR_W'(seg_end);
      w_d = last_iss ? '0 : w_q + ADDR_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q    <= '0;
      s_q    <= '0;
      w_q    <= '0;
      relu_q <= 1'b0;
    end else begin
      o_q <= o_d;
      s_q <= s_d;
      w_q <= w_d;
      if (state_q == IDLE && start && !abort) relu_q <= relu_en;
    end
  end
  // Lane products, floor-shifted back to the Q format; lanes past IN_LEN contribute nothing
  always_comb begin
    logic signed [2*DATA_W-1:0] p2;
    p2 = '0;
    for (int k = 0; k < LANES; k++) begin
      p2 = $signed(in_rd_data[k*DATA_W +: DATA_W]) * $signed(w_rd_data[k*DATA_W +: DATA_W]);
      prod_d[k] = '0;
      if (int'(ts_q[MEM_LAT-1]) * LANES + k < IN_LEN) prod_d[k] = p2 >>> FRAC_W;
    end
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++)
      sum = sum + {{(ACC_W-2*DATA_W){prod_q[k][2*DATA_W-1]}}, prod_q[k]};
    acc_d = (fp_q ? '0 : acc_q) + sum + (lp_q ? {{(ACC_W-DATA_W){bp_q[DATA_W-1]}}, bp_q} : '0);
  end
  // Saturate when the bits above the output sign are not a pure sign extension
  always_comb begin
    hi    = acc_q[ACC_W-1:DATA_W-1];
    ovf   = !(&hi || ~|hi);
    sat_v = ovf ? {acc_q[ACC_W-1], {(DATA_W-1){~acc_q[ACC_W-1]}}} : acc_q[DATA_W-1:0];
    act_v = (relu_q && sat_v[DATA_W-1]) ? '0 : sat_v;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      f_q  <= '0;
      l_q  <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        to_q[i] <= '0;
        ts_q[i] <= '0;
      end
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
      bp_q  <= '0;
      vp_q  <= 1'b0;
      fp_q  <= 1'b0;
      lp_q  <= 1'b0;
      op_q  <= '0;
      va_q  <= 1'b0;
      la_q  <= 1'b0;
      oa_q  <= '0;
      acc_q <= '0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else begin
      v_q[0]  <= iss;
      f_q[0]  <= s_q == '0;
      l_q[0]  <= seg_end;
      to_q[0] <= o_q;
      ts_q[0] <= s_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        v_q[i]  <= v_q[i-1];
        f_q[i]  <= f_q[i-1];
        l_q[i]  <= l_q[i-1];
        to_q[i] <= to_q[i-1];
        ts_q[i] <= ts_q[i-1];
      end
      if (abort) v_q <= '0;
      vp_q   <= v_q[MEM_LAT-1] && !abort;
      fp_q   <= f_q[MEM_LAT-1];
      lp_q   <= l_q[MEM_LAT-1];
      op_q   <= to_q[MEM_LAT-1];
      prod_q <= prod_d;
      bp_q   <= b_rd_data;
      va_q   <= vp_q && !abort;
      la_q   <= lp_q;
      oa_q   <= op_q;
      if (vp_q) acc_q <= acc_d;
      we_q <= va_q && la_q && !abort;
      if (va_q && la_q) begin
        wa_q <= oa_q;
        wd_q <= act_v;
      end
    end
  end
endmodule

// File: tb/tb_dense_layer_engine.sv
// tb_dense_layer_engine: scoreboard bench for dense_layer_engine at memory latencies 1 and 3
module tb_dense_layer_engine;
  localparam int LANES = 2;
  localparam int IN_LEN = 5;
  localparam int OUT_LEN = 5;
  localparam int SEG = 3;
  localparam int N = OUT_LEN * SEG;
  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
    int          c;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, start, abort, relu_en;
  logic [1:0] busy, done, we;
  logic [7:0] ia [2];
  logic [7:0] wa [2];
  logic [7:0] ba [2];
  logic [7:0] oa [2];
  logic [31:0] id [2];
  logic [31:0] wd [2];
  logic [15:0] bd [2];
  logic [15:0] od [2];
  logic [31:0] xm [SEG];
  logic [31:0] wm [N];
  logic [15:0] bm [OUT_LEN];
  exp_t q0 [$];
  exp_t q3 [$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int wc [2] = '{0, 0};
  int dc [2] = '{0, 0};
  int lastwr [2] = '{0, 0};
  int exp_done [2] = '{-1, -1};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int ML = (g == 0) ? 1 : 3;
    logic [31:0] xp [ML];
    logic [31:0] wp [ML];
    logic [15:0] bp [ML];
    always @(posedge clk) begin
      xp[0] <= xm[ia[g]];
      wp[0] <= wm[wa[g]];
      bp[0] <= bm[ba[g]];
      for (int i = 1; i < ML; i++) begin
        xp[i] <= xp[i-1];
        wp[i] <= wp[i-1];
        bp[i] <= bp[i-1];
      end
    end
    assign id[g] = xp[ML-1];
    assign wd[g] = wp[ML-1];
    assign bd[g] = bp[ML-1];
    dense_layer_engine #(
      .DATA_W(16), .FRAC_W(8), .LANES(LANES), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN),
      .ACC_W(40), .MEM_LAT(ML), .ADDR_W(8)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .relu_en(relu_en),
      .busy(busy[g]), .done(done[g]),
      .in_rd_addr(ia[g]), .in_rd_data(id[g]),
      .w_rd_addr(wa[g]), .w_rd_data(wd[g]),
      .b_rd_addr(ba[g]), .b_rd_data(bd[g]),
      .out_wr_en(we[g]), .out_wr_addr(oa[g]), .out_wr_data(od[g])
    );
  end
  function automatic logic [15:0] model(input int o, input logic r);
    logic signed [39:0] acc;
    logic signed [31:0] p;
    logic signed [15:0] xv, wv;
    acc = {{24{bm[o][15]}}, bm[o]};
    for (int i = 0; i < IN_LEN; i++) begin
      xv = xm[i / LANES][(i % LANES) * 16 +: 16];
      wv = wm[o * SEG + i / LANES][(i % LANES) * 16 +: 16];
      p = xv * wv;
      acc = acc + (p >>> 8);
    end
    if (acc > 40'sd32767) acc = 40'sd32767;
    else if (acc < -40'sd32768) acc = -40'sd32768;
    return (r && acc < 0) ? 16'h0000 : acc[15:0];
  endfunction
  task automatic mon(input int g);
    exp_t e;
    forever begin
      @(negedge clk);
      if (we[g]) begin
        total++;
        wc[g]++;
        lastwr[g] = cyc;
        if ((g == 0 ? q0.size() : q3.size()) == 0) begin
          bad++;
          $display("FAIL wr_unexpected[%0d] addr=%0d data=%h cyc=%0d want no write", g, oa[g], od[g], cyc);
        end else begin
          if (g == 0) e = q0.pop_front();
          else e = q3.pop_front();
          if (oa[g] !== e.a || od[g] !== e.d || cyc != e.c) begin
            bad++;
            $display("FAIL wr[%0d] addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                     g, oa[g], od[g], cyc, e.a, e.d, e.c);
          end
        end
      end
      if (done[g]) begin
        total++;
        dc[g]++;
        if (cyc != exp_done[g]) begin
          bad++;
          $display("FAIL done_time[%0d] cyc=%0d want %0d", g, cyc, exp_done[g]);
        end
      end
    end
  endtask
  task automatic fill(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv, input logic rnd);
    for (int s = 0; s < SEG; s++)
      for (int k = 0; k < LANES; k++) begin
        xm[s][k*16 +: 16] = (s * LANES + k >= IN_LEN) ? 16'h7FFF :
                            rnd ? 16'($urandom_range(0, 1023)) - 16'h0200 : xv;
        for (int o = 0; o < OUT_LEN; o++)
          wm[o*SEG + s][k*16 +: 16] = (s * LANES + k >= IN_LEN) ? 16'h7FFF :
                                      rnd ? 16'($urandom_range(0, 1023)) - 16'h0200 : wv;
      end
    for (int o = 0; o < OUT_LEN; o++) bm[o] = rnd ? 16'($urandom_range(0, 65535)) : bv;
  endtask
  task automatic push(input int c, input logic r);
    exp_t e;
    for (int o = 0; o < OUT_LEN; o++) begin
      e.a = 8'(o);
      e.d = model(o, r);
      e.c = c + o * SEG + SEG + 1 + 3;
      q0.push_back(e);
      e.c = c + o * SEG + SEG + 3 + 3;
      q3.push_back(e);
    end
    exp_done[0] = c + N + 1 + 4;
    exp_done[1] = c + N + 3 + 4;
  endtask
  task automatic do_pass(input logic r, input int again);
    @(posedge clk); #1;
    start = 1'b1;
    relu_en = r;
    push(cyc, r);
    for (int i = 1; i < N + 12; i++) begin
      @(posedge clk); #1;
      start = (i == again);
      relu_en = ~r;
    end
    start = 1'b0;
  endtask
  task automatic test_reset;
    total++;
    if ({busy[0], done[0], we[0], ia[0], wa[0], ba[0], oa[0], od[0]} !== '0) begin
      bad++;
      $display("FAIL reset_outputs0 got=%h want 0", {busy[0], done[0], we[0], ia[0], wa[0], ba[0], oa[0], od[0]});
    end
    total++;
    if ({busy[1], done[1], we[1], ia[1], wa[1], ba[1], oa[1], od[1]} !== '0) begin
      bad++;
      $display("FAIL reset_outputs3 got=%h want 0", {busy[1], done[1], we[1], ia[1], wa[1], ba[1], oa[1], od[1]});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 2'b00 || done !== 2'b00 || we !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b done=%b we=%b want 00 00 00", busy, done, we);
    end
  endtask
  task automatic check_pass(input string nm, input int d0, input int d3);
    total++;
    if (q0.size() != 0 || q3.size() != 0) begin
      bad++;
      $display("FAIL %s_pending q0=%0d q3=%0d want 0 0", nm, q0.size(), q3.size());
    end
    total++;
    if (dc[0] != d0 + 1 || dc[1] != d3 + 1) begin
      bad++;
      $display("FAIL %s_done_count got=%0d,%0d want %0d,%0d", nm, dc[0], dc[1], d0 + 1, d3 + 1);
    end
  endtask
  task automatic test_basic;
    int d0, d3;
    fill(16'h0100, 16'h0080, 16'h0000, 1'b0);
    d0 = dc[0]; d3 = dc[1];
    do_pass(1'b0, 0);
    check_pass("basic", d0, d3);
  endtask
  task automatic test_bias_relu;
    int d0, d3;
    fill(16'h0100, 16'hFF80, 16'h0080, 1'b0);
    d0 = dc[0]; d3 = dc[1];
    do_pass(1'b0, 0);
    check_pass("bias_linear", d0, d3);
    d0 = dc[0]; d3 = dc[1];
    do_pass(1'b1, 0);
    check_pass("bias_relu", d0, d3);
  endtask
  task automatic test_saturation;
    int d0, d3;
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    d0 = dc[0]; d3 = dc[1];
    do_pass(1'b0, 0);
    check_pass("sat_pos", d0, d3);
    fill(16'h7FFF, 16'h8000, 16'h7FFF, 1'b0);
    d0 = dc[0]; d3 = dc[1];
    do_pass(1'b0, 0);
    check_pass("sat_neg", d0, d3);
  endtask
  task automatic test_tail;
    int d0, d3;
    fill(16'h0100, 16'h0100, 16'h0000, 1'b0);
    d0 = dc[0]; d3 = dc[1];
    do_pass(1'b1, 0);
    check_pass("tail", d0, d3);
  endtask
  task automatic test_random;
    int d0, d3;
    for (int n = 0; n < 3; n++) begin
      fill(16'h0, 16'h0, 16'h0, 1'b1);
      d0 = dc[0]; d3 = dc[1];
      do_pass(1'($urandom_range(0, 1)), 0);
      check_pass("random", d0, d3);
    end
  endtask
  task automatic test_back_to_back;
    int d0, d3, w0;
    fill(16'h0040, 16'h0300, 16'hFFC0, 1'b0);
    d0 = dc[0]; d3 = dc[1]; w0 = wc[0];
    do_pass(1'b0, 5);
    check_pass("restart_ignored", d0, d3);
    total++;
    if (wc[0] != w0 + OUT_LEN) begin
      bad++;
      $display("FAIL restart_write_count got=%0d want %0d", wc[0] - w0, OUT_LEN);
    end
  endtask
  task automatic test_latency;
    int d0, d3;
    fill(16'h0100, 16'h0080, 16'h0010, 1'b0);
    d0 = dc[0]; d3 = dc[1];
    do_pass(1'b0, 0);
    check_pass("latency", d0, d3);
    total++;
    if (lastwr[1] - lastwr[0] != 2) begin
      bad++;
      $display("FAIL latency_shift got=%0d want 2", lastwr[1] - lastwr[0]);
    end
  endtask
  task automatic test_abort;
    int d0, d3, w0, n;
    fill(16'h0100, 16'h0100, 16'h0000, 1'b0);
    d0 = dc[0]; d3 = dc[1]; w0 = wc[0];
    @(posedge clk); #1;
    start = 1'b1;
    relu_en = 1'b0;
    push(cyc, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 2'b11) begin
      bad++;
      $display("FAIL busy_after_start got=%b want 11", busy);
    end
    n = 0;
    while (n < 100 && wc[0] < w0 + 3) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n == 100) begin
      bad++;
      $display("FAIL abort_wait_timeout writes=%0d want 3", wc[0] - w0);
    end
    abort = 1'b1;
    q0.delete();
    q3.delete();
    exp_done[0] = -1;
    exp_done[1] = -1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++;
    if (busy !== 2'b00) begin
      bad++;
      $display("FAIL busy_after_abort got=%b want 00", busy);
    end
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (wc[0] != w0 + 3 || dc[0] != d0 || dc[1] != d3) begin
      bad++;
      $display("FAIL abort_quiet writes=%0d dones=%0d,%0d want 3 %0d,%0d", wc[0] - w0, dc[0], dc[1], d0, d3);
    end
    d0 = dc[0]; d3 = dc[1];
    do_pass(1'b0, 0);
    check_pass("after_abort", d0, d3);
  endtask
  task automatic test_reset_mid;
    int d0, d3;
    fill(16'h0200, 16'hFE00, 16'h0100, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    relu_en = 1'b0;
    push(cyc, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N + 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete();
    q3.delete();
    exp_done[0] = -1;
    exp_done[1] = -1;
    #1;
    total++;
    if ({busy, done, we, ia[0], wa[0], ba[0], oa[0], od[0], ia[1], wa[1], ba[1], oa[1], od[1]} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs busy=%b done=%b we=%b od0=%h od3=%h want all 0", busy, done, we, od[0], od[1]);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = dc[0]; d3 = dc[1];
    fill(16'h0100, 16'h0180, 16'hFF00, 1'b0);
    do_pass(1'b1, 0);
    check_pass("after_reset", d0, d3);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    relu_en = 1'b0;
    fill(16'h0, 16'h0, 16'h0, 1'b0);
    fork
      mon(0);
      mon(1);
    join_none
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_bias_relu;
    test_saturation;
    test_tail;
    test_random;
    test_back_to_back;
    test_latency;
    test_abort;
    test_reset_mid;
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
